// File: rtl/kv_cmd_exec.sv
// Key/value command executor: parses SET/GET/DEL frames from a byte stream and answers over a ready/valid byte port.
// Optional macro KV_CMD_CLEAR_EN adds opcode 0x04 CLEAR (invalidate whole table).
module kv_cmd_exec #(
  parameter int DEPTH = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       overrun
);

  localparam int IW = $clog2(DEPTH);

  localparam logic [7:0] OP_SET   = 8'h01;
  localparam logic [7:0] OP_GET   = 8'h02;
  localparam logic [7:0] OP_DEL   = 8'h03;
  localparam logic [7:0] OP_CLEAR = 8'h04;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;
  localparam logic [7:0] RSP_UNK  = 8'h3F;

  typedef enum logic [2:0] {IDLE, KEY, VAL, EXEC, RESP} state_t;

  state_t     state_q, state_d;
  logic [7:0] op_q, op_d;
  logic [7:0] key_q, key_d;
  logic [7:0] val_q, val_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic [7:0] resp2_q, resp2_d;
  logic       more_q, more_d;
  logic       overrun_q, overrun_d;

  logic       tbl_valid_q [DEPTH];
  logic       tbl_valid_d [DEPTH];
  logic [7:0] tbl_key_q   [DEPTH];
  logic [7:0] tbl_key_d   [DEPTH];
  logic [7:0] tbl_val_q   [DEPTH];
  logic [7:0] tbl_val_d   [DEPTH];

  logic          hit, free_found;
  logic [IW-1:0] hit_idx, free_idx;
  logic          op_known, op_nokey;

  // Parallel match against every valid entry, plus lowest-index free slot.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit && tbl_valid_q[i] && (tbl_key_q[i] == key_q)) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
      if (!free_found && !tbl_valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
  end

  always_comb begin
`ifdef KV_CMD_CLEAR_EN
    op_known = (rx_data == OP_SET) || (rx_data == OP_GET) ||
               (rx_data == OP_DEL) || (rx_data == OP_CLEAR);
    op_nokey = (rx_data == OP_CLEAR);
`else
    op_known = (rx_data == OP_SET) || (rx_data == OP_GET) || (rx_data == OP_DEL);
    op_nokey = 1'b0;
`endif
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    key_d       = key_q;
    val_d       = val_q;
    tx_data_d   = tx_data_q;
    resp2_d     = resp2_q;
    more_d      = more_q;
    overrun_d   = overrun_q;
    tbl_valid_d = tbl_valid_q;
    tbl_key_d   = tbl_key_q;
    tbl_val_d   = tbl_val_q;

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (op_known) begin
            op_d    = rx_data;
            state_d = op_nokey ? EXEC : KEY;
          end else begin
            tx_data_d = RSP_UNK;
            more_d    = 1'b0;
            state_d   = RESP;
          end
        end
      end
      KEY: begin
        if (rx_valid) begin
          key_d   = rx_data;
          state_d = (op_q == OP_SET) ? VAL : EXEC;
        end
      end
      VAL: begin
        if (rx_valid) begin
          val_d   = rx_data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (rx_valid) overrun_d = 1'b1;
        state_d = RESP;
        more_d  = 1'b0;
        case (op_q)
          OP_SET: begin
            if (hit) begin
              tbl_val_d[hit_idx] = val_q;
              tx_data_d          = RSP_ACK;
            end else if (free_found) begin
              tbl_valid_d[free_idx] = 1'b1;
              tbl_key_d[free_idx]   = key_q;
              tbl_val_d[free_idx]   = val_q;
              tx_data_d             = RSP_ACK;
            end else begin
              tx_data_d = RSP_NAK;
            end
          end
          OP_GET: begin
            if (hit) begin
              tx_data_d = RSP_ACK;
              resp2_d   = tbl_val_q[hit_idx];
              more_d    = 1'b1;
            end else begin
              tx_data_d = RSP_NAK;
            end
          end
          OP_DEL: begin
            if (hit) begin
              tbl_valid_d[hit_idx] = 1'b0;
              tx_data_d            = RSP_ACK;
            end else begin
              tx_data_d = RSP_NAK;
            end
          end
`ifdef KV_CMD_CLEAR_EN
          OP_CLEAR: begin
            for (int i = 0; i < DEPTH; i++) tbl_valid_d[i] = 1'b0;
            tx_data_d = RSP_ACK;
          end
`endif
          default: tx_data_d = RSP_UNK;
        endcase
      end
      RESP: begin
        if (rx_valid) overrun_d = 1'b1;
        if (tx_ready) begin
          if (more_q) begin
            tx_data_d = resp2_q;
            more_d    = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      key_q       <= '0;
      val_q       <= '0;
      tx_data_q   <= '0;
      resp2_q     <= '0;
      more_q      <= 1'b0;
      overrun_q   <= 1'b0;
      tbl_valid_q <= '{default: 1'b0};
      tbl_key_q   <= '{default: 8'h00};
      tbl_val_q   <= '{default: 8'h00};
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      key_q       <= key_d;
      val_q       <= val_d;
      tx_data_q   <= tx_data_d;
      resp2_q     <= resp2_d;
      more_q      <= more_d;
      overrun_q   <= overrun_d;
      tbl_valid_q <= tbl_valid_d;
      tbl_key_q   <= tbl_key_d;
      tbl_val_q   <= tbl_val_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = (state_q == RESP);
  assign busy     = (state_q == EXEC) || (state_q == RESP);
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_kv_cmd_exec.sv
// Self-checking bench for kv_cmd_exec: expected response bytes are queued as frames are sent
// and compared by a monitor at every tx handshake.
module tb_kv_cmd_exec;

  logic       clock;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       overrun;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q [$];

  kv_cmd_exec #(.DEPTH(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .overrun  (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard: every accepted tx byte must match the oldest expected byte.
  always @(negedge clock) begin
    if (!reset && tx_valid && tx_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL tx_unexpected: got %02h, nothing expected", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          errors++;
          $display("[TB] FAIL tx_byte: got %02h, expected %02h", tx_data, e);
        end
      end
    end
  end

  // All tasks start and end just after a rising edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clock); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      @(posedge clock); #1;
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("[TB] FAIL wait_idle: timeout, %0d bytes pending, busy=%0b", exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 4;
    if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_valid: got %0b, expected 0", tx_valid); end
    if (tx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_tx_data: got %02h, expected 00", tx_data); end
    if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL reset_busy: got %0b, expected 0", busy); end
    if (overrun !== 1'b0)  begin errors++; $display("[TB] FAIL reset_overrun: got %0b, expected 0", overrun); end
  endtask

  task automatic test_set_get();
    exp_q.push_back(8'h06);
    send_byte(8'h01); send_byte(8'd45); send_byte(8'd9);
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL set_latency_early: tx_valid=%0b, expected 0", tx_valid); end
    @(posedge clock); #1;
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h06) begin
      errors++;
      $display("[TB] FAIL set_latency: tx_valid=%0b tx_data=%02h, expected 1/06", tx_valid, tx_data);
    end
    wait_idle();
    exp_q.push_back(8'h06); exp_q.push_back(8'h09);
    send_byte(8'h02); send_byte(8'd45);
    wait_idle();
  endtask

  task automatic test_miss_del();
    exp_q.push_back(8'h15);
    send_byte(8'h02); send_byte(8'd67);
    wait_idle();
    exp_q.push_back(8'h06);
    send_byte(8'h01); send_byte(8'd3); send_byte(8'd101);
    wait_idle();
    exp_q.push_back(8'h06);
    send_byte(8'h03); send_byte(8'd3);
    wait_idle();
    exp_q.push_back(8'h15);
    send_byte(8'h02); send_byte(8'd3);
    wait_idle();
    exp_q.push_back(8'h15);
    send_byte(8'h03); send_byte(8'd3);
    wait_idle();
  endtask

  task automatic test_full_table();
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      exp_q.push_back(8'h06);
      send_byte(8'h01); send_byte(8'(k)); send_byte(8'(k + 16));
      wait_idle();
    end
    exp_q.push_back(8'h15);
    send_byte(8'h01); send_byte(8'd9); send_byte(8'd99);
    wait_idle();
    exp_q.push_back(8'h06);
    send_byte(8'h01); send_byte(8'd4); send_byte(8'd77);
    wait_idle();
    exp_q.push_back(8'h06); exp_q.push_back(8'd77);
    send_byte(8'h02); send_byte(8'd4);
    wait_idle();
    exp_q.push_back(8'h06); exp_q.push_back(8'd24);
    send_byte(8'h02); send_byte(8'd8);
    wait_idle();
  endtask

  task automatic test_unknown_clear();
    exp_q.push_back(8'h3F);
    send_byte(8'h65);
    wait_idle();
    exp_q.push_back(8'h06); exp_q.push_back(8'd77);
    send_byte(8'h02); send_byte(8'd4);
    wait_idle();
`ifdef KV_CMD_CLEAR_EN
    exp_q.push_back(8'h06);
    send_byte(8'h04);
    wait_idle();
    exp_q.push_back(8'h15);
    send_byte(8'h02); send_byte(8'd4);
    wait_idle();
`else
    exp_q.push_back(8'h3F);
    send_byte(8'h04);
    wait_idle();
    exp_q.push_back(8'h06); exp_q.push_back(8'd77);
    send_byte(8'h02); send_byte(8'd4);
    wait_idle();
`endif
  endtask

  task automatic test_backpressure_overrun();
    int n = 0;
    exp_q.push_back(8'h06);
    send_byte(8'h01); send_byte(8'd4); send_byte(8'd77);
    wait_idle();
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL overrun_pre: got %0b, expected 0", overrun); end
    tx_ready = 1'b0;
    exp_q.push_back(8'h06); exp_q.push_back(8'd77);
    send_byte(8'h02); send_byte(8'd4);
    while (!tx_valid && n < 20) begin @(posedge clock); #1; n++; end
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h06) begin
        errors++;
        $display("[TB] FAIL hold_stable: cycle %0d tx_valid=%0b tx_data=%02h, expected 1/06", c, tx_valid, tx_data);
      end
      if (c == 4) send_byte(8'h55);
      else begin @(posedge clock); #1; end
    end
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL overrun_set: got %0b, expected 1", overrun); end
    tx_ready = 1'b1;
    wait_idle();
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL overrun_sticky: got %0b, expected 1", overrun); end
    exp_q.push_back(8'h06); exp_q.push_back(8'd77);
    send_byte(8'h02); send_byte(8'd4);
    wait_idle();
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'h01); send_byte(8'd45);
    reset    = 1'b1;
    rx_data  = 8'h02;
    rx_valid = 1'b1;
    @(posedge clock); #1;
    checks += 2;
    if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_tx_valid: got %0b, expected 0", tx_valid); end
    if (overrun !== 1'b0)  begin errors++; $display("[TB] FAIL rst_mid_overrun: got %0b, expected 0", overrun); end
    @(posedge clock); #1;
    reset    = 1'b0;
    rx_valid = 1'b0;
    @(posedge clock); #1;
    checks += 3;
    if (tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_after_tx_valid: got %0b, expected 0", tx_valid); end
    if (overrun !== 1'b0)  begin errors++; $display("[TB] FAIL rst_after_overrun: got %0b, expected 0", overrun); end
    if (busy !== 1'b0)     begin errors++; $display("[TB] FAIL rst_after_busy: got %0b, expected 0", busy); end
    exp_q.push_back(8'h15);
    send_byte(8'h02); send_byte(8'd45);
    wait_idle();
  endtask

  initial begin
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    @(posedge clock); #1;
    test_reset();
    test_set_get();
    test_miss_del();
    test_full_table();
    test_unknown_clear();
    test_backpressure_overrun();
    test_reset_mid_frame();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL leftover: %0d expected bytes never sent, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kv_cmd_exec.md
KV_CMD_EXEC -- requirements
Module: kv_cmd_exec

Interface
REQ-001 The module SHALL have parameter DEPTH, default 8, giving the number of key/value table entries (2..16).
REQ-002 The module SHALL have port clock, input, 1, the single system clock; all logic is on its rising edge.
REQ-003 The module SHALL have port reset, input, 1, a synchronous, active-high reset.
REQ-004 The module SHALL have port rx_data, input, 8, a command byte from the upstream serial command extractor.
REQ-005 The module SHALL have port rx_valid, input, 1, a one-cycle strobe marking rx_data as valid; there is no backpressure.
REQ-006 The module SHALL have port tx_data, output, 8, a response byte to the downstream serial transmitter.
REQ-007 The module SHALL have port tx_valid, output, 1, marking the response byte as valid.
REQ-008 The module SHALL have port tx_ready, input, 1; a byte is consumed when tx_valid and tx_ready are both high.
REQ-009 The module SHALL have port busy, output, 1, high in the EXEC and RESP states.
REQ-010 The module SHALL have port overrun, output, 1, a sticky flag set when a byte is dropped.

Function
REQ-011 A frame SHALL be an opcode byte, then a key byte, then a value byte, with the value byte present for SET only.
REQ-012 The opcodes SHALL be 0x01 SET, 0x02 GET and 0x03 DEL; every other opcode is unknown.
REQ-013 The FSM SHALL have the states IDLE, KEY, VAL, EXEC and RESP, with these transitions:
- IDLE to KEY on a valid opcode.
- KEY to VAL on a byte when the opcode is SET.
- KEY to EXEC on a byte for GET or DEL.
- VAL to EXEC on a byte.
- EXEC to RESP after exactly one cycle.
- RESP to IDLE after the last response byte handshakes.
REQ-014 An unknown opcode in IDLE SHALL go directly to RESP with the single response 0x3F, and SHALL consume no key byte.
REQ-015 Each table entry SHALL hold valid (1 bit), key (8 bits) and value (8 bits), and lookup SHALL compare all valid entries in parallel in EXEC.
REQ-016 SET with a key that hits SHALL overwrite the value and respond 0x06.
REQ-017 SET with a key that misses SHALL write the lowest-index free entry and respond 0x06; if no entry is free, the table is unchanged and the response is 0x15.
REQ-018 GET with a key that hits SHALL respond with two bytes, 0x06 then the value; a miss SHALL respond 0x15.
REQ-019 DEL with a key that hits SHALL clear that entry's valid bit and respond 0x06; a miss SHALL respond 0x15.
REQ-020 The table SHALL be updated at the EXEC edge; the first response byte SHALL drive tx_valid in the cycle after EXEC, giving 2 cycles from the last rx byte to tx_valid.
REQ-021 tx_data SHALL be held stable while tx_valid=1 and tx_ready=0; with tx_ready held high, a two-byte GET response SHALL take 2 consecutive cycles.
REQ-022 An rx_valid arriving in EXEC or RESP SHALL be dropped and SHALL set overrun; the frame in progress completes normally.
REQ-023 Key 0x00 and value 0x00 SHALL be legal data with no special meaning.

Reset
REQ-024 Reset SHALL be synchronous and active-high.
REQ-025 Reset SHALL clear all valid bits and force the FSM to IDLE.
REQ-026 Reset SHALL force tx_valid=0, tx_data=0x00, busy=0 and overrun=0, and it SHALL override rx_valid in the same cycle.
REQ-027 Reset mid-frame SHALL discard any partial frame and any pending response.

Configuration
REQ-028 With macro KV_CMD_CLEAR_EN defined, opcode 0x04 CLEAR SHALL take no key byte, SHALL invalidate all entries in EXEC and SHALL respond 0x06.
REQ-029 Without KV_CMD_CLEAR_EN, 0x04 SHALL be an unknown opcode and SHALL respond 0x3F.

Verification
REQ-030 The bench SHALL cover SET: bytes 0x01,45,9 -> tx 0x06 exactly 2 cycles after byte 9; then GET 0x02,45 -> tx 0x06,0x09.
REQ-031 The bench SHALL cover a GET miss and DEL: GET 0x02,67 -> 0x15; SET 3,101 then DEL 0x03,3 -> 0x06; GET 3 -> 0x15.
REQ-032 The bench SHALL cover a full table: SET keys 1..8 -> eight 0x06; SET key 9 -> 0x15; SET key 4 value 77 -> 0x06, then GET 4 -> 0x06,77.
REQ-033 The bench SHALL cover an unknown opcode and CLEAR: opcode 101 (0x65) -> 0x3F, after which the next byte is treated as an opcode; 0x04 -> 0x06 with the table empty when KV_CMD_CLEAR_EN is defined, else 0x3F.
REQ-034 The bench SHALL cover backpressure and overrun: hold tx_ready=0 for 10 cycles during a GET response -> tx_data stable, no byte lost; an rx byte injected in RESP -> overrun=1 and the response is unchanged.
REQ-035 The bench SHALL cover reset mid-frame: reset after 0x01,45 -> next GET 45 responds 0x15, with tx_valid=0 and overrun=0 during and immediately after reset.
